// File: rtl/sar_search_ctrl_pkg.sv
// Shared definitions for the SAR binary-search controller and the ALU sequencer.
// Holds the controller state encoding and the probe-counter width rule.
package sar_search_ctrl_pkg;

  localparam int SAR_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } sar_state_e;

  // Worst case is WIDTH+1 probes, so the counter must hold values up to WIDTH+1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/sar_search_ctrl.sv
// Binary-search controller: drives comparator trials, narrows [lo,hi] from the
// eq/greater/lesser flags and reports the located value, status and probe count.
module sar_search_ctrl
  import sar_search_ctrl_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH_DEFAULT,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             enable,
  output logic [WIDTH-1:0] trial,
  input  logic             eq,
  input  logic             greater,
  input  logic             lesser,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             error,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] probes
);

  localparam logic [WIDTH-1:0] ALL_ONES    = '1;
  localparam logic [WIDTH-1:0] FIRST_TRIAL = ALL_ONES >> 1;

  sar_state_e       state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] probes_q, probes_d;
  logic             found_q, found_d;
  logic             error_q, error_d;

  // Midpoints are formed one bit wider so lo+hi cannot overflow before the shift.
  logic [WIDTH:0] mid_up;
  logic [WIDTH:0] mid_dn;

  assign mid_up = {1'b0, trial_q} + {1'b0, hi_q} + {{WIDTH{1'b0}}, 1'b1};
  assign mid_dn = {1'b0, lo_q} + {1'b0, trial_q} - {{WIDTH{1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      hi_q     <= ALL_ONES;
      trial_q  <= '0;
      result_q <= '0;
      probes_q <= '0;
      found_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      probes_q <= probes_d;
      found_q  <= found_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    trial_d  = trial_q;
    result_d = result_q;
    probes_d = probes_q;
    found_d  = found_q;
    error_d  = error_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          lo_d     = '0;
          hi_d     = ALL_ONES;
          trial_d  = FIRST_TRIAL;
          probes_d = '0;
          found_d  = 1'b0;
          error_d  = 1'b0;
          state_d  = PROBE;
        end
      end

      PROBE: begin
        probes_d = probes_q + CNT_W'(1);
        case ({eq, greater, lesser})
          3'b100: begin
            result_d = trial_q;
            found_d  = 1'b1;
            state_d  = DONE;
          end
          3'b010: begin
            if (trial_q == hi_q) begin
              found_d = 1'b0;
              state_d = DONE;
            end else begin
              lo_d    = trial_q + WIDTH'(1);
              trial_d = WIDTH'(mid_up >> 1);
            end
          end
          3'b001: begin
            if (trial_q == lo_q) begin
              found_d = 1'b0;
              state_d = DONE;
            end else begin
              hi_d    = trial_q - WIDTH'(1);
              trial_d = WIDTH'(mid_dn >> 1);
            end
          end
          default: begin
            error_d = 1'b1;
            found_d = 1'b0;
            state_d = DONE;
          end
        endcase
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign enable = (state_q == PROBE);
  assign busy   = (state_q == PROBE);
  assign done   = (state_q == DONE);
  assign trial  = trial_q;
  assign result = result_q;
  assign probes = probes_q;
  assign found  = found_q;
  assign error  = error_q;

endmodule
